instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage of the five-stage pipeline, directly upstream of the instruction RAM and decode. Holds the program counter, drives the byte address into the combinational instruction RAM, and captures the returned word into the IF/ID pipeline register with its PC. Handles stall and branch/jump redirect from later stages. Stops fetching once the halt word has been fetched.

## Interface
- `RESET_PC`, default 0: byte address fetched first after reset.
- `HALT_WORD`, default 32'hFFFF_FFFF: encoding that terminates fetch.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hazard unit hold: PC and IF/ID keep their values.
- `redirect`  in  1  taken branch/jump from EX: load `redirect_pc`, flush IF/ID.
- `redirect_pc`  in  `WORD`  byte target address.
- `imem_addr`  out  `WORD`  byte address to the instruction RAM, equal to the PC register.
- `imem_data`  in  `WORD`  instruction word returned combinationally for `imem_addr`.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_instr`  out  `WORD`  fetched instruction.
- `ifid_pc`  out  `WORD`  address the instruction was fetched from.
- `ifid_pc4`  out  `WORD`  `ifid_pc` + 4.
- `halted`  out  1  fetch stopped on `HALT_WORD`.
- `fetch_fault`  out  1  misaligned redirect detected; sticky until reset.
- `fetch_count`  out  `WORD`  number of instructions captured with valid=1.

## Operation
- States:
  - BOOT: entered while `rst`=0; lasts the first cycle after reset release; the PC is presented but nothing is captured.
  - RUN: normal fetch.
  - HALT: fetch stopped.
- Reset values: PC=`RESET_PC`; `ifid_valid`=0; `ifid_instr`, `ifid_pc`, `ifid_pc4`=0; `halted`=0; `fetch_fault`=0; `fetch_count`=0; state=BOOT.
- BOOT→RUN unconditionally. No capture happens and the PC is unchanged.
- RUN priority per cycle is redirect > stall > advance.
  - Redirect: PC←`redirect_pc`, `ifid_valid`←0. The other IF/ID fields are don't-care but hold their values. Redirect overrides a simultaneous stall.
  - Stall, no redirect: PC, all IF/ID fields and `fetch_count` hold.
  - Advance: IF/ID←{1, `imem_data`, PC, PC+4}; PC←PC+4; `fetch_count`+1.
- Halt detection: on an advance with `imem_data`==`HALT_WORD`, the halt word is captured valid and counted, the PC freezes at its own address (no +4), and the state moves to HALT. `halted`=1 from the following cycle.
- HALT behaviour:
  - With `stall`=0: IF/ID clears `ifid_valid` after one cycle, so the halt word is passed down exactly once.
  - With `stall`=1: IF/ID holds.
  - A redirect in HALT means the halt was on a squashed path: PC←`redirect_pc`, `ifid_valid`←0, `halted`←0, state→RUN.
- Arithmetic: PC+4 wraps modulo 2^`WORD`. `fetch_count` wraps. Unaligned PCs are legal fetch addresses, because the RAM assembles unaligned words.
- `rst`=0 in any state, including mid-stall or mid-redirect, returns everything to reset values on that edge.

## Timing
- `imem_addr` is driven from the PC register, not combinationally from the inputs.
- Fetch latency is one cycle: the word at PC appears on `ifid_*` after the next rising edge.
- `redirect` and `stall` are sampled at the rising edge. A redirect costs one bubble, which is the flushed slot.
- `halted` asserts one cycle after the halt word is captured.

## Configuration
- Macro `IF_ALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0]`≠0 in RUN or HALT sets `fetch_fault`=1 and moves to HALT with `halted`=1.
  - PC is not loaded and `ifid_valid`←0.
  - Only reset clears the fault.
- Undefined: `fetch_fault` is tied 0, and misaligned targets are accepted as normal redirects.

## Structure
- Shared `constants.v` provides `WORD`, `BYTE`, the state encodings `IF_BOOT`, `IF_RUN`, `IF_HALT`, and the default halt word.
- Natural sub-module: `ifid_reg`, the IF/ID register with load, hold and flush controls. The PC and FSM stay in `instruction_fetch`.

## Test plan
- Reset then 4 free-running cycles with RAM words 0x11,0x22,0x33: `ifid_pc` sequence 0,4,8; `ifid_valid`=1 from the cycle after BOOT; `fetch_count`=3.
- Stall held 2 cycles at PC=8 → `ifid_pc`=4 and `ifid_instr`=0x22 held; `imem_addr`=8 held; count unchanged.
- Redirect to 0x40 together with stall → next cycle `ifid_valid`=0 and `imem_addr`=0x40; the cycle after, `ifid_pc`=0x40.
- Halt word at 0xC: captured once with valid=1; `halted`=1 the next cycle; `imem_addr` stays 0xC; then `ifid_valid`=0.
- In HALT, redirect to 0x20 → `halted`=0, fetch resumes at 0x20.
- With `IF_ALIGN_CHECK_EN`, redirect to 0x22 → `fetch_fault`=1, `halted`=1, PC unchanged. Without the macro → fetch proceeds at 0x22.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types: word sizes, FSM encodings, the IF/ID bundle.
// IF_ALIGN_CHECK_EN enables the misaligned-redirect fault check.
package instruction_fetch_pkg;

  localparam int WORD = 32;
  localparam int BYTE = 8;

  localparam logic [WORD-1:0] INSTR_BYTES = WORD'(WORD / BYTE);
  localparam logic [WORD-1:0] HALT_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_t;

  typedef struct packed {
    logic            valid;
    logic [WORD-1:0] instr;
    logic [WORD-1:0] pc;
    logic [WORD-1:0] pc4;
  } if_id_t;

  function automatic logic misaligned(
    input logic [WORD-1:0] addr
  );
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: load a new bundle, hold, or flush.
// Flush only drops valid; the payload keeps its last value.
module ifid_reg
  import instruction_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, BOOT/RUN/HALT control, IF/ID capture.
// IF_ALIGN_CHECK_EN: misaligned redirects fault instead of loading.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC  = '0,
  parameter logic [WORD-1:0] HALT_WORD = HALT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_data,
  output logic            ifid_valid,
  output logic [WORD-1:0] ifid_instr,
  output logic [WORD-1:0] ifid_pc,
  output logic [WORD-1:0] ifid_pc4,
  output logic            halted,
  output logic            fetch_fault,
  output logic [WORD-1:0] fetch_count
);

  if_state_t       state;
  logic [WORD-1:0] pc;
  logic [WORD-1:0] pc_next4;
  logic [WORD-1:0] count;
  logic            halted_q;
  logic            fault_q;
  logic            bad_tgt;
  logic            is_halt;
  logic            load;
  logic            flush;
  if_id_t          ifid_d;
  if_id_t          ifid_q;

  assign pc_next4 = pc + INSTR_BYTES;
  assign is_halt  = imem_data == HALT_WORD;

`ifdef IF_ALIGN_CHECK_EN
  assign bad_tgt = misaligned(redirect_pc);
`else
  assign bad_tgt = 1'b0;
`endif

  assign ifid_d = '{
    valid: 1'b1,
    instr: imem_data,
    pc:    pc,
    pc4:   pc_next4
  };

  // HALT with no stall keeps flushing so the halt word passes once
  always_comb begin
    load  = 1'b0;
    flush = 1'b0;
    if (state != IF_BOOT) begin
      if (redirect) begin
        flush = 1'b1;
      end else if (!stall) begin
        if (state == IF_RUN) begin
          load = 1'b1;
        end else begin
          flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IF_BOOT;
      pc       <= RESET_PC;
      count    <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state)
        IF_BOOT: begin
          state <= IF_RUN;
        end
        IF_RUN, IF_HALT: begin
          if (redirect) begin
            if (bad_tgt) begin
              fault_q  <= 1'b1;
              halted_q <= 1'b1;
              state    <= IF_HALT;
            end else begin
              pc       <= redirect_pc;
              halted_q <= 1'b0;
              state    <= IF_RUN;
            end
          end else if (!stall && state == IF_RUN) begin
            count <= count + 1'b1;
            if (is_halt) begin
              halted_q <= 1'b1;
              state    <= IF_HALT;
            end else begin
              pc <= pc_next4;
            end
          end
        end
        default: begin
          state <= IF_BOOT;
        end
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign imem_addr   = pc;
  assign ifid_valid  = ifid_q.valid;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_pc4    = ifid_q.pc4;
  assign halted      = halted_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table plus hand sequences,
// expectations queued at drive time and popped after each edge.
module tb_instruction_fetch;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;

`ifdef IF_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] addr;
    logic        h;
    logic        f;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int   errors = 0;
  int   checks = 0;
  int   stepno = 0;
  exp_t exp_q[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4),
    .halted      (halted),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return HW;
      default: return dflt(a);
    endcase
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  function automatic vec_t mkv(
    input logic r, input logic s, input logic rd,
    input logic [31:0] rpc, input logic v,
    input logic [31:0] ins, input logic [31:0] p,
    input logic [31:0] p4, input logic [31:0] a,
    input logic h, input logic f, input logic [31:0] c
  );
    vec_t t;
    t.rst = r;
    t.stall = s;
    t.redir = rd;
    t.rpc = rpc;
    t.e = '{v: v, instr: ins, pc: p, pc4: p4,
            addr: a, h: h, f: f, cnt: c};
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL step %0d %s: got %h want %h",
               stepno, nm, act, want);
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    rst = t.rst;
    stall = t.stall;
    redirect = t.redir;
    redirect_pc = t.rpc;
    exp_q.push_back(t.e);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL step %0d scoreboard: got empty want entry", stepno);
    end else begin
      checks--;
      e = exp_q.pop_front();
      chk("valid", 32'(ifid_valid), 32'(e.v));
      chk("instr", ifid_instr, e.instr);
      chk("pc", ifid_pc, e.pc);
      chk("pc4", ifid_pc4, e.pc4);
      chk("imem_addr", imem_addr, e.addr);
      chk("halted", 32'(halted), 32'(e.h));
      chk("fault", 32'(fetch_fault), 32'(e.f));
      chk("count", fetch_count, e.cnt);
    end
    stepno++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mkv(0,0,0,0, 0,0,0,0,0,0,0,0);
    tbl[1]  = mkv(1,0,0,0, 0,0,0,0,0,0,0,0);
    tbl[2]  = mkv(1,0,0,0, 1,32'h11,0,4,4,0,0,1);
    tbl[3]  = mkv(1,0,0,0, 1,32'h22,4,8,8,0,0,2);
    tbl[4]  = mkv(1,1,0,0, 1,32'h22,4,8,8,0,0,2);
    tbl[5]  = mkv(1,1,0,0, 1,32'h22,4,8,8,0,0,2);
    tbl[6]  = mkv(1,1,1,32'h40, 0,32'h22,4,8,32'h40,0,0,2);
    tbl[7]  = mkv(1,0,0,0, 1,dflt(32'h40),32'h40,32'h44,32'h44,0,0,3);
    tbl[8]  = mkv(1,0,0,0, 1,dflt(32'h44),32'h44,32'h48,32'h48,0,0,4);
    tbl[9]  = mkv(1,0,1,8, 0,dflt(32'h44),32'h44,32'h48,8,0,0,4);
    tbl[10] = mkv(1,0,0,0, 1,32'h33,8,32'hC,32'hC,0,0,5);
    tbl[11] = mkv(1,0,0,0, 1,HW,32'hC,32'h10,32'hC,1,0,6);
    tbl[12] = mkv(1,0,0,0, 0,HW,32'hC,32'h10,32'hC,1,0,6);
    tbl[13] = mkv(1,0,0,0, 0,HW,32'hC,32'h10,32'hC,1,0,6);
    tbl[14] = mkv(1,0,1,32'h20, 0,HW,32'hC,32'h10,32'h20,0,0,6);
    tbl[15] = mkv(1,0,0,0, 1,dflt(32'h20),32'h20,32'h24,32'h24,0,0,7);
    tbl[16] = ALIGN ?
      mkv(1,0,1,32'h22, 0,dflt(32'h20),32'h20,32'h24,32'h24,1,1,7) :
      mkv(1,0,1,32'h22, 0,dflt(32'h20),32'h20,32'h24,32'h22,0,0,7);
    tbl[17] = ALIGN ?
      mkv(1,0,0,0, 0,dflt(32'h20),32'h20,32'h24,32'h24,1,1,7) :
      mkv(1,0,0,0, 1,dflt(32'h22),32'h22,32'h26,32'h26,0,0,8);
    tbl[18] = mkv(0,1,1,32'h80, 0,0,0,0,0,0,0,0);

    repeat (2) @(posedge clk);
    for (int i = 0; i < 19; i++) step(tbl[i]);

    // BOOT ignores redirect; PC wraps; halt held under stall
    step(mkv(1,0,1,32'h40, 0,0,0,0,0,0,0,0));
    step(mkv(1,0,1,32'hFFFF_FFFC, 0,0,0,0,32'hFFFF_FFFC,0,0,0));
    step(mkv(1,0,0,0, 1,32'hA5A5_FFFC,32'hFFFF_FFFC,0,0,0,0,1));
    step(mkv(1,0,0,0, 1,32'h11,0,4,4,0,0,2));
    step(mkv(1,0,0,0, 1,32'h22,4,8,8,0,0,3));
    step(mkv(1,0,0,0, 1,32'h33,8,32'hC,32'hC,0,0,4));
    step(mkv(1,0,0,0, 1,HW,32'hC,32'h10,32'hC,1,0,5));
    step(mkv(1,1,0,0, 1,HW,32'hC,32'h10,32'hC,1,0,5));
    step(mkv(1,1,0,0, 1,HW,32'hC,32'h10,32'hC,1,0,5));
    step(mkv(1,0,0,0, 0,HW,32'hC,32'h10,32'hC,1,0,5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
